mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Arbitrates the single-port unified MIPS32 memory between three requesters:
  - data port (MEM stage LW/SW),
  - instruction-fetch port (IF stage),
  - debug/loader port (memory preload and readback).
- One transaction in flight at a time, with fixed priority plus anti-starvation for fetch.
- Sits between the pipeline and the memory array; the pipeline stalls IF/MEM until its grant and response arrive.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle (range 1..7).
- STARVE_MAX, 4, number of consecutive data-port grants that fetch can lose before it is forced to win.

Ports:
- clk1  in  1  Clock. All logic is on its rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- halted  in  1  Pipeline HALTED flag. While high, fetch requests are masked.
- d_req, i_req, g_req  in  1 each  Request from data, fetch and debug ports.
- d_we, g_we  in  1 each  Write enable. The fetch port is read-only.
- d_addr, i_addr, g_addr  in  ADDR_W each  Word address.
- d_wdata, g_wdata  in  DATA_W each  Write data.
- d_gnt, i_gnt, g_gnt  out  1 each  One-cycle grant pulse.
- d_rvalid, i_rvalid, g_rvalid  out  1 each  One-cycle response or write-ack pulse.
- d_rdata, i_rdata, g_rdata  out  DATA_W each  Read data. Equals mem_rdata while the port's rvalid is high, else 0.
- mem_en, mem_we  out  1 each  Memory strobe and write enable.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_rdata  in  DATA_W  Memory read data.
- busy  out  1  High whenever the FSM is not in IDLE.

Behaviour:
- Reset values: every output is 0, FSM is IDLE, starvation counter is 0, latency counter is 0.
- Reset is asynchronous. Asserting it mid-transaction discards the transaction: no rvalid is issued, and memory is unaffected beyond a mem_en already in progress.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Any eligible request is arbitrated; the next state is ISSUE.
  - Eligible means req=1. For fetch it also requires halted=0.
- ISSUE (1 cycle):
  - The winner's gnt=1 and mem_en=1.
  - mem_we, mem_addr and mem_wdata come from the operands latched at the IDLE→ISSUE edge.
  - Next state is WAIT if MEM_LAT>1, otherwise RESP.
- WAIT: the latency counter counts until MEM_LAT-1 cycles after ISSUE have elapsed, then the FSM moves to RESP.
- RESP (1 cycle):
  - The winner's rvalid=1 and rdata=mem_rdata.
  - Writes also get rvalid, with rdata=0.
  - Arbitration is re-run in this cycle. If any request is eligible, the next state is ISSUE (back-to-back), otherwise IDLE.
- Throughput: one transaction per MEM_LAT+1 cycles.
- Latency: a request seen at edge E gets gnt in cycle E+1 and rvalid in cycle E+1+MEM_LAT.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt.
  - Operands are latched at grant.
  - A req still high in the cycle after gnt is a new request.
- Priority: data > fetch > debug.
  - Exception: when starve_cnt==STARVE_MAX and fetch is eligible, fetch wins over data.
- Starvation counter:
  - Incremented (saturating at STARVE_MAX) on every data grant made while fetch is eligible.
  - Cleared on every fetch grant, and when fetch is not eligible at an arbitration point.
- Debug is granted only when neither data nor fetch is eligible.
- halted rising mid-transaction does not cancel a fetch already granted; its rvalid is still delivered.
- Simultaneous requests from all three ports: exactly one gnt per ISSUE cycle, never two.
- The address is used modulo 2^ADDR_W with no bounds check.

Test Plan:
1. Debug writes 32'd85 to addr 120, then debug reads addr 120 (MEM_LAT=1) → g_gnt at cycles 1 and 3; read g_rvalid at cycle 4 with g_rdata=85; busy low after.
2. d_req (read 120) and i_req (read 0, memory word 32'h28010078) both asserted at cycle 0 → d_gnt first, i_gnt 2 cycles later; i_rdata=32'h28010078.
3. d_req held high continuously together with i_req, STARVE_MAX=4 → grant order D,D,D,D,I,D…; i_gnt appears exactly after the 4th d_gnt.
4. halted=1 with i_req and g_req high → only g_gnt is issued. Deasserting halted → i_gnt at the next arbitration point.
5. MEM_LAT=3, data read → gnt in cycle 1, rvalid in cycle 4, busy high in cycles 1–4.
6. rst_n pulsed low during WAIT → all outputs are 0 immediately; no rvalid after release; a fresh request completes normally.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//   Single-port memory arbiter for a MIPS32 pipeline with a unified
//   instruction/data memory. Three requesters share the memory. Only one
//   transaction is in flight at a time.
//
//   Priority is data > fetch > debug. Fetch also has starvation protection:
//   once it has lost STARVE_MAX consecutive arbitrations to the data port,
//   it wins the next arbitration in which it is eligible.
//
//   Transaction timing (MEM_LAT = L):
//     IDLE/RESP --arbitrate--> ISSUE (gnt, mem_en)
//                           -> WAIT x (L-1) -> RESP (rvalid)
//   RESP arbitrates again, so back-to-back transactions run at one
//   transaction every L+1 cycles.
//
// Ports
//   clk1, rst_n               clock; asynchronous active-low reset
//   halted                    masks fetch requests while high
//   d_/i_/g_req, _we          requests and write enables (fetch is read-only)
//   d_/i_/g_addr, _wdata      word address and write data
//   d_/i_/g_gnt               one-cycle grant pulse (ISSUE cycle)
//   d_/i_/g_rvalid, _rdata    one-cycle response; rdata is 0 outside rvalid
//                             and 0 for write acks
//   mem_en/we/addr/wdata      memory strobe and operands
//   mem_rdata                 memory read data, valid MEM_LAT cycles after
//                             the mem_en cycle
//   busy                      FSM is not IDLE
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              d_req,
    input  logic              i_req,
    input  logic              g_req,
    input  logic              d_we,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              d_gnt,
    output logic              i_gnt,
    output logic              g_gnt,
    output logic              d_rvalid,
    output logic              i_rvalid,
    output logic              g_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] g_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [2:0]      LAT_LAST   = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Port vectors are ordered {debug, fetch, data}.
    state_t            r_state;
    logic [SW-1:0]     r_starve;
    logic [2:0]        r_lat;
    logic [2:0]        r_sel;
    logic              r_we;
    logic [2:0]        r_gnt;
    logic [2:0]        r_rvalid;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_d_el;
    logic              w_i_el;
    logic              w_g_el;
    logic              w_force_i;
    logic [2:0]        w_sel;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [SW-1:0]     w_starve_nxt;

    assign w_d_el = d_req;
    assign w_i_el = i_req & ~halted;
    assign w_g_el = g_req;

    // Fetch overrides data once it has lost STARVE_MAX arbitrations in a row.
    assign w_force_i = w_i_el && (r_starve == STARVE_TOP);

    assign w_sel[0] = w_d_el && !w_force_i;
    assign w_sel[1] = w_i_el && (w_force_i || !w_d_el);
    assign w_sel[2] = w_g_el && !w_d_el && !w_i_el;
    assign w_any    = w_d_el | w_i_el | w_g_el;

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_sel[0]) begin
            w_we    = d_we;
            w_addr  = d_addr;
            w_wdata = d_wdata;
        end else if (w_sel[1]) begin
            w_addr  = i_addr;
        end else if (w_sel[2]) begin
            w_we    = g_we;
            w_addr  = g_addr;
            w_wdata = g_wdata;
        end
    end

    // The counter only tracks losses while fetch is actually waiting; any
    // arbitration where fetch is absent or wins restarts the count.
    always_comb begin
        w_starve_nxt = r_starve;
        if (!w_i_el || w_sel[1]) begin
            w_starve_nxt = '0;
        end else if (w_sel[0] && (r_starve != STARVE_TOP)) begin
            w_starve_nxt = r_starve + SW'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_lat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Strobes are single-cycle; memory operands are only driven
            // during ISSUE.
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                IDLE, RESP: begin
                    r_starve <= w_starve_nxt;
                    if (w_any) begin
                        r_state     <= ISSUE;
                        r_sel       <= w_sel;
                        r_we        <= w_we;
                        r_gnt       <= w_sel;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_we;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (MEM_LAT > 1) begin
                        r_state <= WAIT;
                        r_lat   <= 3'd1;
                    end else begin
                        r_state  <= RESP;
                        r_rvalid <= r_sel;
                    end
                end
                WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state  <= RESP;
                        r_lat    <= '0;
                        r_rvalid <= r_sel;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign d_gnt     = r_gnt[0];
    assign i_gnt     = r_gnt[1];
    assign g_gnt     = r_gnt[2];
    assign d_rvalid  = r_rvalid[0];
    assign i_rvalid  = r_rvalid[1];
    assign g_rvalid  = r_rvalid[2];
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

    // Read data is exposed only during a read response; write acks carry 0.
    assign d_rdata = (r_rvalid[0] && !r_we) ? mem_rdata : '0;
    assign i_rdata = r_rvalid[1] ? mem_rdata : '0;
    assign g_rdata = (r_rvalid[2] && !r_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_arbiter
//   Directed bench for mips_mem_arbiter. Instance A uses MEM_LAT=1 and
//   instance B uses MEM_LAT=3. Each instance has its own behavioural memory.
// ---------------------------------------------------------------------------
module tb_mips_mem_arbiter;

    logic        clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // ---------------- instance A (MEM_LAT = 1) ----------------
    logic        rst_n, halted, d_req, i_req, g_req, d_we, g_we;
    logic [9:0]  d_addr, i_addr, g_addr;
    logic [31:0] d_wdata, g_wdata;
    logic        d_gnt, i_gnt, g_gnt, d_rvalid, i_rvalid, g_rvalid;
    logic [31:0] d_rdata, i_rdata, g_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
        .clk1(clk1), .rst_n(rst_n), .halted(halted),
        .d_req(d_req), .i_req(i_req), .g_req(g_req),
        .d_we(d_we), .g_we(g_we),
        .d_addr(d_addr), .i_addr(i_addr), .g_addr(g_addr),
        .d_wdata(d_wdata), .g_wdata(g_wdata),
        .d_gnt(d_gnt), .i_gnt(i_gnt), .g_gnt(g_gnt),
        .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .g_rvalid(g_rvalid),
        .d_rdata(d_rdata), .i_rdata(i_rdata), .g_rdata(g_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [31:0] amem [1024];
    logic [31:0] a_rd;
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) amem[mem_addr] <= mem_wdata;
            else        a_rd <= amem[mem_addr];
        end
    end
    assign mem_rdata = a_rd;

    // ---------------- instance B (MEM_LAT = 3) ----------------
    logic        b_rst_n, b_halted, b_d_req, b_i_req, b_g_req, b_d_we, b_g_we;
    logic [9:0]  b_d_addr, b_i_addr, b_g_addr;
    logic [31:0] b_d_wdata, b_g_wdata;
    logic        b_d_gnt, b_i_gnt, b_g_gnt, b_d_rvalid, b_i_rvalid, b_g_rvalid;
    logic [31:0] b_d_rdata, b_i_rdata, b_g_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [9:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
        .clk1(clk1), .rst_n(b_rst_n), .halted(b_halted),
        .d_req(b_d_req), .i_req(b_i_req), .g_req(b_g_req),
        .d_we(b_d_we), .g_we(b_g_we),
        .d_addr(b_d_addr), .i_addr(b_i_addr), .g_addr(b_g_addr),
        .d_wdata(b_d_wdata), .g_wdata(b_g_wdata),
        .d_gnt(b_d_gnt), .i_gnt(b_i_gnt), .g_gnt(b_g_gnt),
        .d_rvalid(b_d_rvalid), .i_rvalid(b_i_rvalid), .g_rvalid(b_g_rvalid),
        .d_rdata(b_d_rdata), .i_rdata(b_i_rdata), .g_rdata(b_g_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    logic [31:0] bmem [1024];
    logic [31:0] b_sh0, b_sh1, b_sh2;
    always @(posedge clk1) begin
        if (b_mem_en) begin
            if (b_mem_we) bmem[b_mem_addr] <= b_mem_wdata;
            else          b_sh0 <= bmem[b_mem_addr];
        end
        b_sh1 <= b_sh0;
        b_sh2 <= b_sh1;
    end
    assign b_mem_rdata = b_sh2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; b_rst_n = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({d_gnt, i_gnt, g_gnt, d_rvalid, i_rvalid, g_rvalid, mem_en, mem_we, busy,
             mem_addr, mem_wdata, d_rdata, i_rdata, g_rdata} !== '0)
            $display("FAIL reset_a_outputs: some output nonzero (busy=%b mem_en=%b)", busy, mem_en);
        else pass_cnt++;
        total_cnt++;
        if ({b_d_gnt, b_mem_en, b_busy, b_d_rvalid} !== 4'b0)
            $display("FAIL reset_b_outputs: got %b want 0000", {b_d_gnt, b_mem_en, b_busy, b_d_rvalid});
        else pass_cnt++;
        rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({busy, b_busy, mem_en} !== 3'b0) $display("FAIL reset_idle: got %b want 000", {busy, b_busy, mem_en});
        else pass_cnt++;
    endtask

    // Debug write 85 -> addr 120 then read it back; also preloads addr 0.
    task automatic test_debug_rw();
        g_req = 1'b1; g_we = 1'b1; g_addr = 10'd120; g_wdata = 32'd85;
        tick(); // cycle 1
        total_cnt++;
        if ({g_gnt, mem_en, mem_we} !== 3'b111) $display("FAIL t1_wr_gnt: got %b want 111", {g_gnt, mem_en, mem_we});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 10'd120 || mem_wdata !== 32'd85)
            $display("FAIL t1_wr_operands: got addr=%0d data=%0d want 120/85", mem_addr, mem_wdata);
        else pass_cnt++;
        g_we = 1'b0;
        tick(); // cycle 2
        total_cnt++;
        if (g_rvalid !== 1'b1 || g_rdata !== 32'd0) $display("FAIL t1_wr_ack: got rvalid=%b rdata=%0d want 1/0", g_rvalid, g_rdata);
        else pass_cnt++;
        tick(); // cycle 3
        total_cnt++;
        if ({g_gnt, mem_en, mem_we} !== 3'b110) $display("FAIL t1_rd_gnt: got %b want 110", {g_gnt, mem_en, mem_we});
        else pass_cnt++;
        g_req = 1'b0;
        tick(); // cycle 4
        total_cnt++;
        if (g_rvalid !== 1'b1 || g_rdata !== 32'd85) $display("FAIL t1_rd_data: got rvalid=%b rdata=%0d want 1/85", g_rvalid, g_rdata);
        else pass_cnt++;
        tick(); // cycle 5
        total_cnt++;
        if (busy !== 1'b0 || g_rdata !== 32'd0) $display("FAIL t1_idle: got busy=%b rdata=%0d want 0/0", busy, g_rdata);
        else pass_cnt++;
        g_req = 1'b1; g_we = 1'b1; g_addr = 10'd0; g_wdata = 32'h28010078;
        tick(); g_req = 1'b0; g_we = 1'b0;
        tick(); tick();
    endtask

    task automatic test_priority();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120;
        i_req = 1'b1; i_addr = 10'd0;
        tick(); // cycle 1
        total_cnt++;
        if ({d_gnt, i_gnt} !== 2'b10) $display("FAIL t2_first_gnt: got d,i=%b want 10", {d_gnt, i_gnt});
        else pass_cnt++;
        d_req = 1'b0;
        tick(); // cycle 2
        total_cnt++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'd85 || i_gnt !== 1'b0)
            $display("FAIL t2_d_resp: got rvalid=%b rdata=%0d i_gnt=%b want 1/85/0", d_rvalid, d_rdata, i_gnt);
        else pass_cnt++;
        tick(); // cycle 3
        total_cnt++;
        if ({d_gnt, i_gnt} !== 2'b01) $display("FAIL t2_second_gnt: got d,i=%b want 01", {d_gnt, i_gnt});
        else pass_cnt++;
        i_req = 1'b0;
        tick(); // cycle 4
        total_cnt++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h28010078 || d_rvalid !== 1'b0)
            $display("FAIL t2_i_resp: got rvalid=%b rdata=%h d_rvalid=%b want 1/28010078/0", i_rvalid, i_rdata, d_rvalid);
        else pass_cnt++;
        tick();
    endtask

    // All three ports held; debug must never win, fetch wins after 4 data grants.
    task automatic test_starvation();
        logic [1:0] seq [6];
        logic [1:0] expd [6];
        int ng = 0;
        expd[0] = 2'd0; expd[1] = 2'd0; expd[2] = 2'd0;
        expd[3] = 2'd0; expd[4] = 2'd1; expd[5] = 2'd0;
        for (int k = 0; k < 6; k++) seq[k] = 2'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'd120;
        i_req = 1'b1; i_addr = 10'd0;
        g_req = 1'b1; g_we = 1'b0; g_addr = 10'd0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (d_gnt | i_gnt | g_gnt) begin
                total_cnt++;
                if ($countones({d_gnt, i_gnt, g_gnt}) != 1)
                    $display("FAIL t3_onehot: cycle %0d got d,i,g=%b want one-hot", c, {d_gnt, i_gnt, g_gnt});
                else pass_cnt++;
                if (ng < 6) seq[ng] = d_gnt ? 2'd0 : (i_gnt ? 2'd1 : 2'd2);
                ng++;
            end
        end
        d_req = 1'b0; i_req = 1'b0; g_req = 1'b0;
        total_cnt++;
        if (ng != 6) $display("FAIL t3_grant_count: got %0d want 6", ng);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            total_cnt++;
            if (seq[k] !== expd[k]) $display("FAIL t3_order: grant %0d got port %0d want %0d (0=D 1=I 2=G)", k, seq[k], expd[k]);
            else pass_cnt++;
        end
        tick(); tick();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL t3_idle: got busy=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_halted();
        halted = 1'b1;
        i_req = 1'b1; i_addr = 10'd0;
        g_req = 1'b1; g_we = 1'b0; g_addr = 10'd120;
        tick(); // cycle 1
        total_cnt++;
        if ({i_gnt, g_gnt} !== 2'b01) $display("FAIL t4_halt_gnt: got i,g=%b want 01", {i_gnt, g_gnt});
        else pass_cnt++;
        g_req = 1'b0;
        tick(); // cycle 2
        total_cnt++;
        if (g_rvalid !== 1'b1 || g_rdata !== 32'd85) $display("FAIL t4_g_resp: got rvalid=%b rdata=%0d want 1/85", g_rvalid, g_rdata);
        else pass_cnt++;
        tick(); // cycle 3
        total_cnt++;
        if ({busy, i_gnt} !== 2'b00) $display("FAIL t4_masked: got busy,i_gnt=%b want 00", {busy, i_gnt});
        else pass_cnt++;
        halted = 1'b0;
        tick(); // cycle 4
        total_cnt++;
        if (i_gnt !== 1'b1) $display("FAIL t4_unhalt_gnt: got i_gnt=%b want 1", i_gnt);
        else pass_cnt++;
        i_req = 1'b0;
        halted = 1'b1;
        tick(); // cycle 5
        total_cnt++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h28010078)
            $display("FAIL t4_halt_midflight: got rvalid=%b rdata=%h want 1/28010078", i_rvalid, i_rdata);
        else pass_cnt++;
        halted = 1'b0;
        tick();
    endtask

    task automatic test_latency3();
        b_g_req = 1'b1; b_g_we = 1'b1; b_g_addr = 10'd5; b_g_wdata = 32'hCAFE0005;
        tick(); b_g_req = 1'b0; b_g_we = 1'b0;
        tick(); tick(); tick(); tick();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'd5;
        tick(); // cycle 1
        total_cnt++;
        if ({b_d_gnt, b_mem_en, b_busy} !== 3'b111) $display("FAIL t5_gnt: got gnt,en,busy=%b want 111", {b_d_gnt, b_mem_en, b_busy});
        else pass_cnt++;
        b_d_req = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            tick();
            total_cnt++;
            if ({b_busy, b_d_rvalid, b_d_gnt} !== 3'b100)
                $display("FAIL t5_wait: cycle %0d got busy,rvalid,gnt=%b want 100", c, {b_busy, b_d_rvalid, b_d_gnt});
            else pass_cnt++;
        end
        tick(); // cycle 4
        total_cnt++;
        if ({b_busy, b_d_rvalid} !== 2'b11 || b_d_rdata !== 32'hCAFE0005)
            $display("FAIL t5_resp: got busy,rvalid=%b rdata=%h want 11/cafe0005", {b_busy, b_d_rvalid}, b_d_rdata);
        else pass_cnt++;
        tick(); // cycle 5
        total_cnt++;
        if (b_busy !== 1'b0) $display("FAIL t5_idle: got busy=%b want 0", b_busy);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic seen_rv = 1'b0;
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'd5;
        tick(); // cycle 1
        b_d_req = 1'b0;
        tick(); // cycle 2: WAIT
        total_cnt++;
        if (b_busy !== 1'b1) $display("FAIL t6_in_wait: got busy=%b want 1", b_busy);
        else pass_cnt++;
        b_rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({b_d_gnt, b_i_gnt, b_g_gnt, b_d_rvalid, b_i_rvalid, b_g_rvalid, b_mem_en, b_mem_we, b_busy,
             b_mem_addr, b_mem_wdata, b_d_rdata, b_i_rdata, b_g_rdata} !== '0)
            $display("FAIL t6_async_clear: got busy=%b en=%b want all 0", b_busy, b_mem_en);
        else pass_cnt++;
        tick();
        b_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b_d_rvalid | b_busy) seen_rv = 1'b1;
        end
        total_cnt++;
        if (seen_rv !== 1'b0) $display("FAIL t6_no_stale_rvalid: got activity=%b want 0", seen_rv);
        else pass_cnt++;
        b_d_req = 1'b1;
        tick();
        total_cnt++;
        if (b_d_gnt !== 1'b1) $display("FAIL t6_fresh_gnt: got %b want 1", b_d_gnt);
        else pass_cnt++;
        b_d_req = 1'b0;
        tick(); tick(); tick();
        total_cnt++;
        if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'hCAFE0005)
            $display("FAIL t6_fresh_resp: got rvalid=%b rdata=%h want 1/cafe0005", b_d_rvalid, b_d_rdata);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        halted = 1'b0; d_req = 1'b0; i_req = 1'b0; g_req = 1'b0; d_we = 1'b0; g_we = 1'b0;
        d_addr = '0; i_addr = '0; g_addr = '0; d_wdata = '0; g_wdata = '0;
        b_halted = 1'b0; b_d_req = 1'b0; b_i_req = 1'b0; b_g_req = 1'b0; b_d_we = 1'b0; b_g_we = 1'b0;
        b_d_addr = '0; b_i_addr = '0; b_g_addr = '0; b_d_wdata = '0; b_g_wdata = '0;
        test_reset();
        test_debug_rw();
        test_priority();
        test_starvation();
        test_halted();
        test_latency3();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
